therm_to_bin_pipe: RTL and testbench
====================================

# therm_to_bin_pipe

Parametrised, pipelined thermometer-to-binary encoder for the flash-ADC comparator bank. It generalises the fixed 32-bit combinational encoder to any power-of-two input width and registers every stage for timing closure. It adds a valid/ready handshake with backpressure and optional bubble correction with a saturating bubble-error counter. It sits between the comparator sampling flops and the sample FIFO.

## Interface
- `IN_W`, 32: thermometer input width; power of two, 4..256.
- `OUT_W`, `$clog2(IN_W)`: binary output width; derived, do not override.
- `ERR_CNT_W`, 16: bubble-error counter width, 1..32.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_therm`  in  IN_W  thermometer code; bit 0 is the lowest level.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the output.
- `out_bin`  out  OUT_W  index of the highest set bit of the (corrected) code; 0 if no bit is set.
- `out_zero`  out  1  (corrected) code was all-zero.
- `out_bubble`  out  1  input was not a legal thermometer code.
- `err_cnt`  out  ERR_CNT_W  saturating count of accepted samples with `out_bubble`=1.
- `err_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- Stage C (capture): registers `in_therm` on `in_valid && in_ready`.
- Stage B (bubble correct): `corr[i] = maj(raw[i-1], raw[i], raw[i+1])`, with `raw[-1]=1` and `raw[IN_W]=0`.
  - Legal thermometer codes (contiguous ones from bit 0, including all-zero and all-ones) pass unchanged.
  - `bubble = (corr != raw) || !legal(corr)`.
- Stage E (encode): priority encoder on `corr`.
  - `out_bin` = highest set index, so 0xFF gives 7 and 0xFFFFFFFF gives 31.
  - All-zero input gives `out_bin=0`, `out_zero=1`; this disambiguates it from 0x1, which gives 0 with `out_zero=0`.
- Flow control is a global stall: `stall = out_valid && !out_ready`, and `in_ready = !stall`.
  - While stalled, every stage register and valid bit holds.
  - With no stall, valid bits shift forward each cycle and bubbles (invalid slots) collapse naturally.
- `err_cnt` increments by 1 when a sample with `out_bubble=1` completes a handshake (`out_valid && out_ready`).
  - It saturates at all-ones; it does not wrap.
  - If `err_clr` and an increment coincide, `err_cnt` becomes 0 (clear wins).
- Reset values: all valid bits 0, `in_ready=1` after reset, `out_bin=0`, `out_zero=0`, `out_bubble=0`, `err_cnt=0`, data registers 0.

## Timing
- Latency, bubble fix compiled in: 3 cycles from the accepting edge to `out_valid`.
- Latency, bubble fix compiled out: 2 cycles (stage B removed).
- Throughput is 1 sample/cycle when `out_ready=1`.
- `in_ready` is combinational from `out_ready`. This is a documented exception to registered I/O and is acceptable for this point-to-point link.
- Output stability: while `out_valid=1 && out_ready=0`, `out_bin`, `out_zero` and `out_bubble` are held stable.
- Reset asserted mid-pipeline:
  - All in-flight samples are discarded immediately (asynchronous).
  - `err_cnt` is cleared.
  - After deassertion, the first accepted sample appears after the full latency.

## Configuration
- Macro: `THERM_BUBBLE_FIX_EN`.
- Defined:
  - Stage B is present and latency is 3.
  - `out_bubble` and `err_cnt` are live.
- Undefined:
  - No majority correction and latency is 2.
  - The encoder takes the highest set bit of the raw code, which matches the legacy priority behaviour.
  - `out_bubble` and `err_cnt` are tied to 0 and `err_clr` is ignored.
  - Ports are unchanged.

## Structure
- Package `therm_pkg`:
  - `localparam` limits `IN_W_MIN`/`IN_W_MAX`.
  - Function `therm_legal(vec)`.
  - Function `maj3`.
  - Typedef `therm_stage_t` (valid, data, bubble).
- Sub-module `therm_prio_enc`:
  - Combinational, parametrised by `IN_W`.
  - Outputs `bin` and `zero`.
  - Reused by the ADC calibration logic.
- The top module holds the stage registers, stall logic and error counter.
- Elaboration-time check: `IN_W` must be a power of two in range, otherwise `$fatal`.

## Test plan
- `IN_W=32`, bubble fix on, `out_ready=1`: send 0x000000FF → 3 cycles later `out_bin=7`, `out_zero=0`, `out_bubble=0`. Send 0xFFFFFFFF → `out_bin=31`.
- Input 0x00000000 → `out_bin=0`, `out_zero=1`. Input 0x00000001 → `out_bin=0`, `out_zero=0`.
- Bubble: 0x000000F7 → `out_bin=7`, `out_bubble=1`, `err_cnt` increments 0→1. Without `THERM_BUBBLE_FIX_EN`, the same input gives `out_bin=7`, `out_bubble=0` at latency 2.
- Backpressure:
  - Stream the codes for values 0..9 (one per cycle, from 0x1 for 0 through 0x3FF for 9) with `out_ready` low for cycles 4–7.
  - Required: `in_ready=0` during the stall, held output stable, no loss or duplication, outputs in order 0..9.
- Saturation: `ERR_CNT_W=4`, 20 bubble samples → `err_cnt=15`. Then `err_clr` concurrent with a bubble handshake → `err_cnt=0`.
- Reset mid-stream: assert `rst_n=0` with 3 samples in flight → `out_valid` falls immediately and `err_cnt=0`. After release, a new sample for value 5 (0x3F) emerges alone with `out_bin=5`.

Source files
------------

// File: rtl/therm_pkg.sv
// therm_pkg: shared limits, helpers and stage type for the thermometer encoders.
package therm_pkg;
    localparam int IN_W_MIN = 4;
    localparam int IN_W_MAX = 256;

    typedef struct packed {
        logic                valid;
        logic [IN_W_MAX-1:0] data;
        logic                bubble;
    } therm_stage_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Contiguous ones from bit 0: adding one carries through them and clears every set bit.
    function automatic logic therm_legal(input logic [IN_W_MAX-1:0] vec);
        return (vec & (vec + IN_W_MAX'(1))) == '0;
    endfunction
endpackage

// File: rtl/therm_prio_enc.sv
// therm_prio_enc: combinational highest-set-bit encoder with an all-zero flag.
module therm_prio_enc #(
    parameter int IN_W  = 32,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  vec,
    output logic [OUT_W-1:0] bin,
    output logic             zero
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < IN_W; i++)
            if (vec[i]) bin = OUT_W'(i);
        zero = ~|vec;
    end
endmodule

// File: rtl/therm_to_bin_pipe.sv
// therm_to_bin_pipe: pipelined thermometer-to-binary encoder with valid/ready and global stall.
// THERM_BUBBLE_FIX_EN adds the majority-correction stage, out_bubble and the saturating err_cnt.
module therm_to_bin_pipe
    import therm_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = $clog2(IN_W),
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_therm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_bin,
    output logic                 out_zero,
    output logic                 out_bubble,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);
    if ((IN_W & (IN_W - 1)) != 0 || IN_W < IN_W_MIN || IN_W > IN_W_MAX) begin : g_bad_w
        $fatal(1, "therm_to_bin_pipe: IN_W=%0d must be a power of two in [%0d,%0d]", IN_W, IN_W_MIN, IN_W_MAX);
    end

    logic             stall;
    logic             c_valid_q, c_valid_d;
    logic [IN_W-1:0]  c_data_q, c_data_d;
    logic             o_valid_q, o_valid_d;
    logic [OUT_W-1:0] o_bin_q, o_bin_d;
    logic             o_zero_q, o_zero_d;
    logic             o_bubble_q, o_bubble_d;
    logic [IN_W-1:0]  enc_in;
    logic             enc_valid;
    logic             enc_bubble;
    logic [OUT_W-1:0] enc_bin;
    logic             enc_zero;

    assign stall     = o_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = o_valid_q;
    assign out_bin   = o_bin_q;
    assign out_zero  = o_zero_q;

    therm_prio_enc #(.IN_W(IN_W), .OUT_W(OUT_W)) u_enc (
        .vec  (enc_in),
        .bin  (enc_bin),
        .zero (enc_zero)
    );

    always_comb begin
        c_valid_d  = stall ? c_valid_q : in_valid;
        c_data_d   = (in_valid && !stall) ? in_therm : c_data_q;
        o_valid_d  = stall ? o_valid_q : enc_valid;
        o_bin_d    = (enc_valid && !stall) ? enc_bin : o_bin_q;
        o_zero_d   = (enc_valid && !stall) ? enc_zero : o_zero_q;
        o_bubble_d = (enc_valid && !stall) ? enc_bubble : o_bubble_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid_q  <= 1'b0;
            c_data_q   <= '0;
            o_valid_q  <= 1'b0;
            o_bin_q    <= '0;
            o_zero_q   <= 1'b0;
            o_bubble_q <= 1'b0;
        end else begin
            c_valid_q  <= c_valid_d;
            c_data_q   <= c_data_d;
            o_valid_q  <= o_valid_d;
            o_bin_q    <= o_bin_d;
            o_zero_q   <= o_zero_d;
            o_bubble_q <= o_bubble_d;
        end
    end

`ifdef THERM_BUBBLE_FIX_EN
    logic                 b_valid_q, b_valid_d;
    logic [IN_W-1:0]      b_data_q, b_data_d;
    logic                 b_bubble_q, b_bubble_d;
    logic [IN_W+1:0]      raw_ext;
    logic [IN_W-1:0]      corr;
    logic [IN_W_MAX-1:0]  corr_ext;
    logic                 err_inc;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    assign enc_in     = b_data_q;
    assign enc_valid  = b_valid_q;
    assign enc_bubble = b_bubble_q;
    assign out_bubble = o_bubble_q;
    assign err_cnt    = err_q;

    // Pad below with a 1 and above with a 0 so the end bits vote like a legal code.
    always_comb begin
        raw_ext = {1'b0, c_data_q, 1'b1};
        corr = '0;
        for (int i = 0; i < IN_W; i++)
            corr[i] = maj3(raw_ext[i], raw_ext[i+1], raw_ext[i+2]);
        corr_ext = '0;
        corr_ext[IN_W-1:0] = corr;
        b_valid_d  = stall ? b_valid_q : c_valid_q;
        b_data_d   = (c_valid_q && !stall) ? corr : b_data_q;
        b_bubble_d = (c_valid_q && !stall) ? ((corr != c_data_q) || !therm_legal(corr_ext)) : b_bubble_q;
        err_inc    = o_valid_q && out_ready && o_bubble_q;
        err_d      = err_clr ? '0 : (err_inc && !(&err_q)) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_q  <= 1'b0;
            b_data_q   <= '0;
            b_bubble_q <= 1'b0;
            err_q      <= '0;
        end else begin
            b_valid_q  <= b_valid_d;
            b_data_q   <= b_data_d;
            b_bubble_q <= b_bubble_d;
            err_q      <= err_d;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign enc_in         = c_data_q;
    assign enc_valid      = c_valid_q;
    assign enc_bubble     = 1'b0;
    assign out_bubble     = 1'b0;
    assign err_cnt        = '0;
`endif
endmodule

// File: tb/tb_therm_to_bin_pipe.sv
// tb_therm_to_bin_pipe: directed and randomized checks against a behavioural scoreboard model.
module tb_therm_to_bin_pipe;
`ifdef THERM_BUBBLE_FIX_EN
    localparam bit FIX = 1'b1;
    localparam int LAT = 3;
`else
    localparam bit FIX = 1'b0;
    localparam int LAT = 2;
`endif
    localparam int ERR_MAX = 15;

    typedef struct packed {
        logic [4:0] bin;
        logic       zero;
        logic       bubble;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_therm;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_bin;
    logic        out_zero;
    logic        out_bubble;
    logic [3:0]  err_cnt;
    logic        err_clr;

    int   total = 0;
    int   bad = 0;
    int   out_cnt = 0;
    int   exp_err = 0;
    exp_t q[$];
    logic stall_prev = 1'b0;
    logic [4:0] p_bin;
    logic p_zero;
    logic p_bubble;

    therm_to_bin_pipe #(.IN_W(32), .ERR_CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_therm   (in_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_zero   (out_zero),
        .out_bubble (out_bubble),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Majority by vote count, legality by popcount, highest bit by floor(log2).
    function automatic exp_t model(input logic [31:0] raw);
        logic [33:0] ext;
        logic [31:0] corr;
        int k;
        exp_t e;
        corr = raw;
        e.bubble = 1'b0;
        if (FIX) begin
            ext = {1'b0, raw, 1'b1};
            for (int i = 0; i < 32; i++)
                corr[i] = (32'(ext[i]) + 32'(ext[i+1]) + 32'(ext[i+2])) >= 2;
            k = $countones(corr);
            e.bubble = (corr != raw) || (corr != ((k == 32) ? 32'hFFFF_FFFF : (32'd1 << k) - 32'd1));
        end
        e.zero = (corr == 32'd0);
        e.bin  = e.zero ? 5'd0 : 5'($clog2({32'd0, corr} + 64'd1) - 1);
        return e;
    endfunction

    function automatic logic [31:0] rand_code();
        logic [31:0] c;
        int lvl;
        lvl = $urandom_range(0, 32);
        c = (lvl == 32) ? 32'hFFFF_FFFF : (32'd1 << lvl) - 32'd1;
        if ($urandom_range(0, 3) == 0) c = c ^ (32'd1 << $urandom_range(0, 31));
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            exp_err = 0;
            stall_prev = 1'b0;
        end else begin
            chk("err_cnt", 32'(err_cnt), exp_err);
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_bin", 32'(out_bin), 32'(p_bin));
                chk("hold_zero", 32'(out_zero), 32'(p_zero));
                chk("hold_bubble", 32'(out_bubble), 32'(p_bubble));
            end
            e.bubble = 1'b0;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) begin
                    chk("extra_output", 32'(out_bin), 32'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("bin", 32'(out_bin), 32'(e.bin));
                    chk("zero", 32'(out_zero), 32'(e.zero));
                    chk("bubble", 32'(out_bubble), 32'(e.bubble));
                end
            end
            if (err_clr && FIX) exp_err = 0;
            else if (out_valid && out_ready && e.bubble && exp_err < ERR_MAX) exp_err++;
            if (in_valid && in_ready) q.push_back(model(in_therm));
            stall_prev = out_valid && !out_ready;
            p_bin = out_bin;
            p_zero = out_zero;
            p_bubble = out_bubble;
        end
    end

    task automatic single(input logic [31:0] code, input int eb, input logic ez, input logic ebub);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_therm = code;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LAT);
        chk("single_bin", 32'(out_bin), eb);
        chk("single_zero", 32'(out_zero), 32'(ez));
        chk("single_bubble", 32'(out_bubble), 32'(ebub));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int v;
        int base;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_therm = '0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_bin", 32'(out_bin), 0);
        chk("rst_out_zero", 32'(out_zero), 0);
        chk("rst_out_bubble", 32'(out_bubble), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        single(32'h0000_00FF, 7, 1'b0, 1'b0);
        single(32'hFFFF_FFFF, 31, 1'b0, 1'b0);
        single(32'h0000_0000, 0, 1'b1, 1'b0);
        single(32'h0000_0001, 0, 1'b0, 1'b0);
        single(32'h0000_00F7, 7, 1'b0, FIX);
        chk("bubble_err_cnt", 32'(err_cnt), FIX ? 1 : 0);

        base = out_cnt;
        v = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 4 && c <= 7);
            in_valid = (v < 10);
            in_therm = (32'd1 << (v + 1)) - 32'd1;
            #1;
            if (c >= 4 && c <= 7) begin
                chk("stall_out_valid", 32'(out_valid), 1);
                chk("stall_in_ready", 32'(in_ready), 0);
            end
            if (in_valid && in_ready) v++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        chk("bp_count", out_cnt - base, 10);
        chk("bp_queue_empty", q.size(), 0);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid = ($urandom_range(0, 3) != 0);
            in_therm = rand_code();
            err_clr = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        repeat (8) @(posedge clk);
        chk("rand_queue_empty", q.size(), 0);

        @(posedge clk); #1;
        in_valid = 1'b1;
        in_therm = 32'h0000_00F7;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sat_err_cnt", 32'(err_cnt), FIX ? ERR_MAX : 0);

        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v = 0;
        while (!out_valid && v < 20) begin
            @(posedge clk); #1;
            v++;
        end
        chk("clr_saw_valid", 32'(out_valid), 1);
        chk("clr_pre_err", 32'(err_cnt), FIX ? ERR_MAX : 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_wins", 32'(err_cnt), 0);

        single(32'h0000_00F7, 7, 1'b0, FIX);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_therm = 32'h7;
        @(posedge clk); #1;
        in_therm = 32'hF;
        @(posedge clk); #1;
        in_therm = 32'h1F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight_pre", 32'(out_valid), 1);
        chk("inflight_err_pre", 32'(err_cnt), FIX ? 1 : 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_err_cnt", 32'(err_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = out_cnt;
        single(32'h0000_003F, 5, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        chk("post_rst_count", out_cnt - base, 1);
        chk("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
